phy_tx_paralelo_serial: RTL

//  PHY transmit side of the serial link: serializes 8-bit parallel bytes onto a 1-bit line, MSB first,
//  one bit per clk. Emits comma bytes 0xBC (K28.5 pattern 10111100) for link sync after reset and
//  as idle fill whenever no data is offered. Sits between the upper TX logic (byte stream, valid/ready)
//  and the serial pin; the far-end PHY RX locks on the 0xBC commas.

---
 rtl/phy_pkg.sv | 13 +
 rtl/phy_tx_fifo.sv | 51 +++++
 rtl/phy_tx_paralelo_serial.sv | 114 +++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared PHY definitions: byte width, K28.5 comma byte and TX link state.
// Used by both the PHY TX serializer and the PHY RX.
package phy_pkg;

    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] COMMA_BC = 8'hBC;

    typedef enum logic {
        SYNC,
        ACTIVE
    } tx_state_t;

endpackage

// File: rtl/phy_tx_fifo.sv
// Registered synchronous FIFO for the PHY TX byte input.
// DEPTH must be a power of two; no fall-through, reset flushes the contents.
module phy_tx_fifo
    import phy_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Extra pointer MSB distinguishes full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/phy_tx_paralelo_serial.sv
// PHY TX: byte-to-serial MSB-first, comma preamble and idle fill.
// Optional input FIFO enabled by defining PHY_TX_FIFO_EN.
module phy_tx_paralelo_serial
    import phy_pkg::*;
#(
    parameter int SYNC_BC_COUNT = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              serial_out,
    output logic              byte_start,
    output logic              active_out
);

    localparam int CNT_W = (SYNC_BC_COUNT > 1) ? $clog2(SYNC_BC_COUNT) : 1;
    localparam logic [CNT_W-1:0] BC_LAST = CNT_W'(SYNC_BC_COUNT - 1);

    tx_state_t         state;
    tx_state_t         state_n;
    logic [CNT_W-1:0]  bc_cnt;
    logic [CNT_W-1:0]  bc_cnt_n;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_n;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] cur_n;
    logic              boundary;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;

    assign boundary = (bit_cnt == 3'd0);

`ifdef PHY_TX_FIFO_EN
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;

    assign ready_out  = !fifo_full;
    assign fifo_pop   = (state == ACTIVE) && boundary && !fifo_empty;
    assign load_valid = !fifo_empty;
    assign load_data  = fifo_data;

    phy_tx_fifo #(
        .DW    (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (valid_in && !fifo_full),
        .push_data (data_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    assign ready_out  = (state == ACTIVE) && boundary;
    assign load_valid = valid_in;
    assign load_data  = data_in;
`endif

    always_comb begin
        state_n   = state;
        bc_cnt_n  = bc_cnt;
        bit_cnt_n = bit_cnt - 3'd1;
        cur_n     = cur;
        if (boundary) begin
            bit_cnt_n = 3'd7;
            unique case (state)
                SYNC: begin
                    cur_n    = COMMA_BC;
                    bc_cnt_n = bc_cnt + 1'b1;
                    if (bc_cnt == BC_LAST) begin
                        state_n = ACTIVE;
                    end
                end
                ACTIVE: begin
                    // No user byte available: keep the line busy with a comma.
                    cur_n = load_valid ? load_data : COMMA_BC;
                end
                default: begin
                    state_n = SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SYNC;
            bc_cnt     <= '0;
            bit_cnt    <= 3'd7;
            cur        <= COMMA_BC;
            serial_out <= 1'b0;
            byte_start <= 1'b0;
            active_out <= 1'b0;
        end else begin
            state      <= state_n;
            bc_cnt     <= bc_cnt_n;
            bit_cnt    <= bit_cnt_n;
            cur        <= cur_n;
            serial_out <= cur[bit_cnt];
            byte_start <= (bit_cnt == 3'd7);
            active_out <= (state_n == ACTIVE);
        end
    end

endmodule
